// File: rtl/agc_gain_integrator.sv
// -----------------------------------------------------------------------------
// agc_gain_integrator
//
// Loop-filter integrator of an automatic gain control. Each accepted envelope
// sample produces an error against the target amplitude. The error is scaled
// by an attack or decay step size and added to a clamped gain-exponent
// accumulator. A small FSM selects a fast (shifted) step during initial
// acquisition, a normal step while tracking, and a zero step while frozen.
//
// Ports
//   clk        : clock
//   reset      : asynchronous, active-high reset
//   enb        : clock enable; nothing changes while low
//   in_valid   : env_in carries a sample this cycle
//   env_in     : measured output amplitude, ufix24_En23
//   ref_in     : target amplitude, ufix24_En23
//   mu_attack  : step size used when err < 0 (too loud), ufix16_En20
//   mu_decay   : step size used when err >= 0, ufix16_En20
//   freeze     : level request to hold the gain
//   restart    : synchronous pulse; reload GAIN_INIT and reacquire
//   gain_out   : gain exponent, sfix36_En33
//   gain_valid : one strobe per accepted sample, 3 enabled cycles later
//   state      : IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3
//   sat_hi     : latest update clamped at GAIN_MAX
//   sat_lo     : latest update clamped at GAIN_MIN
// -----------------------------------------------------------------------------
module agc_gain_integrator #(
    parameter logic [35:0] GAIN_INIT  = 36'h000000000,
    parameter logic [35:0] GAIN_MAX   = 36'h600000000,
    parameter logic [35:0] GAIN_MIN   = 36'hA00000000,
    parameter int          ACQ_LEN    = 1024,
    parameter int          FAST_SHIFT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enb,
    input  logic        in_valid,
    input  logic [23:0] env_in,
    input  logic [23:0] ref_in,
    input  logic [15:0] mu_attack,
    input  logic [15:0] mu_decay,
    input  logic        freeze,
    input  logic        restart,
    output logic [35:0] gain_out,
    output logic        gain_valid,
    output logic [1:0]  state,
    output logic        sat_hi,
    output logic        sat_lo
);

    localparam int CNT_W = $clog2(ACQ_LEN + 1);

    // Clamp limits sign-extended to the width of the sum.
    localparam logic signed [37:0] GMAX_EXT = {{2{GAIN_MAX[35]}}, GAIN_MAX};
    localparam logic signed [37:0] GMIN_EXT = {{2{GAIN_MIN[35]}}, GAIN_MIN};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        TRACK   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Pipeline registers
    logic              v1, v2;
    logic signed [24:0] err1;
    logic [18:0]       mu1;
    logic signed [37:0] delta2;
    logic [35:0]       acc;

    // Combinational stage values
    logic signed [24:0] err_c;
    logic [18:0]       mu_base;
    logic [18:0]       mu_c;
    logic              fast;
    logic signed [43:0] prod;
    logic signed [37:0] delta_c;
    logic signed [37:0] delta_eff;
    logic signed [37:0] sum_c;
    logic [35:0]       acc_c;
    logic              hi_c, lo_c;

    // ---------------- stage 1: error and step selection ----------------
    assign err_c   = $signed({1'b0, ref_in}) - $signed({1'b0, env_in});
    assign mu_base = {3'b000, (err_c[24] ? mu_attack : mu_decay)};
    // The sample that leaves IDLE already belongs to acquisition.
    assign fast    = (state_q == IDLE) || (state_q == ACQUIRE);
    assign mu_c    = fast ? (mu_base << FAST_SHIFT) : mu_base;

    // ---------------- stage 2: scale, En43 -> En33 with floor ----------------
    assign prod    = err1 * $signed({1'b0, mu1});
    assign delta_c = 38'(prod >>> 10);

    // ---------------- stage 3: accumulate and clamp ----------------
    assign delta_eff = (state_q == HOLD) ? '0 : delta2;
    assign sum_c     = $signed({{2{acc[35]}}, acc}) + delta_eff;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        acc_c = sum_c[35:0];
        hi_c  = 1'b0;
        lo_c  = 1'b0;
        if (sum_c > GMAX_EXT) begin
            acc_c = GAIN_MAX;
            hi_c  = 1'b1;
        end else if (sum_c < GMIN_EXT) begin
            acc_c = GAIN_MIN;
            lo_c  = 1'b1;
        end
    end

    // ---------------- mode FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (restart) begin
            state_d = ACQUIRE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        cnt_d   = CNT_W'(1);
                        state_d = (ACQ_LEN <= 1) ? TRACK : ACQUIRE;
                    end
                end
                ACQUIRE: begin
                    if (freeze) begin
                        state_d = HOLD;
                    end else if (in_valid) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ACQ_LEN - 1)) begin
                            state_d = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (freeze) begin
                        state_d = HOLD;
                    end
                end
                HOLD: begin
                    // Leaving HOLD resumes tracking; acquisition only restarts on request.
                    if (!freeze) begin
                        state_d = TRACK;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            err1       <= '0;
            mu1        <= '0;
            delta2     <= '0;
            acc        <= GAIN_INIT;
            gain_valid <= 1'b0;
            sat_hi     <= 1'b0;
            sat_lo     <= 1'b0;
        end else if (enb) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (restart) begin
                // Samples in flight belong to the old acquisition and are dropped.
                v1         <= 1'b0;
                v2         <= 1'b0;
                acc        <= GAIN_INIT;
                gain_valid <= 1'b0;
                sat_hi     <= 1'b0;
                sat_lo     <= 1'b0;
            end else begin
                v1 <= in_valid;
                if (in_valid) begin
                    err1 <= err_c;
                    mu1  <= mu_c;
                end
                v2 <= v1;
                if (v1) begin
                    delta2 <= delta_c;
                end
                gain_valid <= v2;
                if (v2) begin
                    acc    <= acc_c;
                    sat_hi <= hi_c;
                    sat_lo <= lo_c;
                end
            end
        end
    end

    assign gain_out = acc;
    assign state    = state_q;

endmodule

// File: tb/tb_agc_gain_integrator.sv
// -----------------------------------------------------------------------------
// tb_agc_gain_integrator
//
// Drives agc_gain_integrator (ACQ_LEN=4, default clamps) through acquisition,
// tracking, hold, saturation, restart, clock-enable gaps and mid-run reset.
// A behavioural model computes each expected gain when a sample is driven and
// pushes it to a scoreboard; a monitor pops one entry per gain_valid strobe.
// -----------------------------------------------------------------------------
module tb_agc_gain_integrator;

    localparam int ACQ_LEN = 4;
    localparam longint GMAX = 64'sd3 <<< 33;
    localparam longint GMIN = -(64'sd3 <<< 33);

    logic        clk = 1'b0;
    logic        reset;
    logic        enb;
    logic        in_valid;
    logic [23:0] env_in;
    logic [23:0] ref_in;
    logic [15:0] mu_attack;
    logic [15:0] mu_decay;
    logic        freeze;
    logic        restart;
    logic [35:0] gain_out;
    logic        gain_valid;
    logic [1:0]  state;
    logic        sat_hi;
    logic        sat_lo;

    agc_gain_integrator #(.ACQ_LEN(ACQ_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .enb        (enb),
        .in_valid   (in_valid),
        .env_in     (env_in),
        .ref_in     (ref_in),
        .mu_attack  (mu_attack),
        .mu_decay   (mu_decay),
        .freeze     (freeze),
        .restart    (restart),
        .gain_out   (gain_out),
        .gain_valid (gain_valid),
        .state      (state),
        .sat_hi     (sat_hi),
        .sat_lo     (sat_lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [35:0] gain;
        logic        hi;
        logic        lo;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    // Model state
    longint m_acc = 0;
    int     m_st  = 0;
    int     m_cnt = 0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    endtask

    // One clock: apply inputs after a rising edge, update the model, advance.
    task automatic step(input logic e, input logic v, input logic [23:0] r,
                        input logic [23:0] en, input logic f, input logic rs);
        longint err, mu, d, sum;
        exp_t   x;
        enb = e; in_valid = v; ref_in = r; env_in = en; freeze = f; restart = rs;
        if (e) begin
            if (rs) begin
                m_acc = 0; m_st = 1; m_cnt = 0;
                sb.delete();
            end else begin
                if (v) begin
                    err = longint'(r) - longint'(en);
                    mu  = (err < 0) ? longint'(mu_attack) : longint'(mu_decay);
                    if (m_st == 0 || m_st == 1) mu = mu << 3;
                    d = (err * mu) >>> 10;
                    if (m_st == 3) d = 0;
                    sum = m_acc + d;
                    x.hi = 1'b0; x.lo = 1'b0;
                    if (sum > GMAX) begin m_acc = GMAX; x.hi = 1'b1; end
                    else if (sum < GMIN) begin m_acc = GMIN; x.lo = 1'b1; end
                    else m_acc = sum;
                    x.gain = m_acc[35:0];
                    sb.push_back(x);
                end
                case (m_st)
                    0: if (v) begin m_cnt = 1; m_st = (ACQ_LEN <= 1) ? 2 : 1; end
                    1: if (f) m_st = 3;
                       else if (v) begin m_cnt++; if (m_cnt == ACQ_LEN) m_st = 2; end
                    2: if (f) m_st = 3;
                    default: if (!f) m_st = 2;
                endcase
            end
        end
        @(posedge clk); #1;
        check("state", 36'(state), 36'(m_st));
    endtask

    task automatic idle(input int n, input logic f);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 24'h0, 24'h0, f, 1'b0);
    endtask

    // Monitor: one scoreboard entry per strobe; everything holds while enb was low.
    logic        last_enb = 1'b1;
    logic [35:0] prev_gain = '0;
    logic        prev_gv = 1'b0;
    always @(posedge clk) last_enb <= enb;

    always @(negedge clk) begin
        if (!reset) begin
            if (!last_enb) begin
                check("hold_gain", gain_out, prev_gain);
                check("hold_gv", 36'(gain_valid), 36'(prev_gv));
            end else if (gain_valid) begin
                if (sb.size() == 0) begin
                    check("stray_gv", 36'(gain_valid), 36'(0));
                end else begin
                    exp_t x;
                    x = sb.pop_front();
                    check("gain", gain_out, x.gain);
                    check("sat_hi", 36'(sat_hi), 36'(x.hi));
                    check("sat_lo", 36'(sat_lo), 36'(x.lo));
                end
            end
            prev_gain = gain_out;
            prev_gv   = gain_valid;
        end
    end

    initial begin
        reset = 1'b1; enb = 1'b1; in_valid = 1'b0; env_in = '0; ref_in = '0;
        mu_attack = 16'h0800; mu_decay = 16'h0400; freeze = 1'b0; restart = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gain", gain_out, 36'h000000000);
        check("rst_gv", 36'(gain_valid), 36'(0));
        check("rst_state", 36'(state), 36'(0));
        reset = 1'b0;
        idle(5, 1'b0);

        // First sample: fast step, three-cycle latency.
        step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("lat_gv_early", 36'(gain_valid), 36'(0));
        idle(1, 1'b0);
        check("lat_gv", 36'(gain_valid), 36'(1));
        check("first_gain", gain_out, 36'h001000000);

        // Finish acquisition back-to-back, then one tracking update.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b0, 1'b0);
        check("acq_done", 36'(state), 36'(2));
        step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("track_step", gain_out, 36'h004200000);

        // Hold: strobes continue, gain frozen.
        idle(1, 1'b1);
        check("hold_state", 36'(state), 36'(3));
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b1, 1'b0);
        idle(4, 1'b1);
        check("hold_const", gain_out, 36'h004200000);
        idle(1, 1'b0);
        check("unhold_state", 36'(state), 36'(2));
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b0, 1'b0);

        // Negative error: attack step with floor rounding.
        mu_attack = 16'h0001;
        step(1'b1, 1'b1, 24'h100000, 24'h300001, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("floor_gain", gain_out, 36'h0045FF7FF);

        // Saturate high, then low.
        mu_decay = 16'hFFFF;
        for (int i = 0; i < 80; i++) step(1'b1, 1'b1, 24'h800000, 24'h000000, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("clamp_hi", gain_out, 36'h600000000);
        check("clamp_hi_flag", 36'(sat_hi), 36'(1));
        mu_attack = 16'hFFFF;
        for (int i = 0; i < 120; i++) step(1'b1, 1'b1, 24'h000000, 24'hFFFFFF, 1'b0, 1'b0);
        idle(4, 1'b0);
        check("clamp_lo", gain_out, 36'hA00000000);
        check("clamp_lo_flag", 36'(sat_lo), 36'(1));

        // Restart with freeze and samples in flight.
        mu_decay = 16'h0400;
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b1, 1'b1);
        check("restart_acc", gain_out, 36'h000000000);
        check("restart_gv", 36'(gain_valid), 36'(0));
        idle(3, 1'b0);

        // Clock-enable gaps around one sample.
        step(1'b0, 1'b1, 24'h400000, 24'h200000, 1'b0, 1'b0);
        step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(i[0], 1'b0, 24'h0, 24'h0, 1'b0, 1'b0);
        idle(2, 1'b0);
        check("enb_gain", gain_out, 36'h001000000);

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 24'h400000, 24'h200000, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        check("arst_gain", gain_out, 36'h000000000);
        check("arst_gv", 36'(gain_valid), 36'(0));
        check("arst_state", 36'(state), 36'(0));
        m_acc = 0; m_st = 0; m_cnt = 0;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4, 1'b0);

        check("sb_empty", 36'(sb.size()), 36'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/agc_gain_integrator.md
AGC_GAIN_INTEGRATOR -- requirements
Module: agc_gain_integrator

Interface
REQ-001 SHALL have parameter GAIN_INIT, default 36'h000000000, accumulator value after reset/restart (sfix36_En33).
REQ-002 SHALL have parameter GAIN_MAX, default 36'h600000000 (+3.0), upper clamp; keeps exp of gain below 32.
REQ-003 SHALL have parameter GAIN_MIN, default 36'hA00000000 (-3.0), lower clamp.
REQ-004 SHALL have parameter ACQ_LEN, default 1024, number of accepted samples spent in ACQUIRE.
REQ-005 SHALL have parameter FAST_SHIFT, default 3, left shift applied to step size in ACQUIRE.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port enb, input, 1, clock enable; no register changes when 0.
REQ-009 SHALL have port in_valid, input, 1, env_in sample valid.
REQ-010 SHALL have port env_in, input, 24, output-amplitude estimate, ufix24_En23.
REQ-011 SHALL have port ref_in, input, 24, target amplitude, ufix24_En23.
REQ-012 SHALL have port mu_attack / mu_decay, input, 16 each, step sizes, ufix16_En20.
REQ-013 SHALL have port freeze, input, 1, level; requests HOLD.
REQ-014 SHALL have port restart, input, 1, synchronous pulse; restarts acquisition.
REQ-015 SHALL have port gain_out, output, 36, gain exponent to exp approximator, sfix36_En33.
REQ-016 SHALL have port gain_valid, output, 1, one-cycle strobe per accepted sample.
REQ-017 SHALL have port state, output, 2, IDLE=0, ACQUIRE=1, TRACK=2, HOLD=3.
REQ-018 SHALL have port sat_hi / sat_lo, output, 1 each, clamp occurred on the latest update.

Function
REQ-019 A sample SHALL be accepted on a clock edge where enb=1 and in_valid=1.
REQ-020 Stage 1 SHALL register err = ref_in - env_in (sfix25_En23, exact) and mu_eff.
REQ-021 mu_eff SHALL be mu_attack when err<0, else mu_decay; in ACQUIRE it SHALL be shifted left FAST_SHIFT (19-bit, no overflow).
REQ-022 Stage 2 SHALL register delta = (err*mu_eff) arithmetic-shifted right 10 (floor), sfix En33, sign-extended to 38 bits.
REQ-023 Stage 3 SHALL form sum = acc + delta in 38 bits; delta SHALL be forced to 0 when state=HOLD.
REQ-024 sum>GAIN_MAX SHALL load GAIN_MAX and set sat_hi; sum<GAIN_MIN SHALL load GAIN_MIN and set sat_lo; otherwise load sum and clear both.
REQ-025 gain_out SHALL equal acc; gain_valid, sat_hi and sat_lo SHALL be registered alongside it; latency SHALL be 3 enabled cycles from acceptance to gain_valid.
REQ-026 IDLE->ACQUIRE SHALL occur on the first accepted sample; that sample SHALL use the ACQUIRE step.
REQ-027 The ACQUIRE counter SHALL count accepted samples; on the ACQ_LEN-th, state SHALL become TRACK for the next cycle.
REQ-028 ACQUIRE or TRACK with freeze=1 SHALL go to HOLD; HOLD with freeze=0 SHALL go to TRACK, never ACQUIRE.
REQ-029 restart=1 (with enb) SHALL set acc=GAIN_INIT, clear the counter, flush pipeline valids and enter ACQUIRE; restart SHALL take priority over freeze.
REQ-030 In HOLD, accepted samples SHALL still produce gain_valid strobes with gain_out unchanged.
REQ-031 When enb=0, all pipeline, state and output registers SHALL hold, including gain_valid.

Reset
REQ-032 On reset: gain_out=GAIN_INIT, gain_valid=0, sat_hi=sat_lo=0, state=IDLE, counter=0, pipeline valids=0.
REQ-033 Reset asserted mid-operation SHALL take effect immediately, independent of clk and enb.

Verification
REQ-034 Reset -> gain_out=36'h000000000, gain_valid=0, state=0; no gain_valid strobes while in_valid=0.
REQ-035 ref=24'h400000, env=24'h200000, mu_decay=16'h0400, one sample at cycle 0 -> state=1; gain_valid at cycle 3; gain_out=36'h001000000.
REQ-036 ACQ_LEN=4, same stimulus back-to-back -> state=2 after 4th sample; 5th update adds 36'h000200000.
REQ-037 ref=24'h800000, env=0, mu_decay=16'hFFFF continuous -> gain_out stops at 36'h600000000 with sat_hi=1; never exceeds.
REQ-038 freeze=1 in TRACK -> state=3; gain_out constant with gain_valid pulsing; freeze=0 -> state=2 and updates resume.
REQ-039 restart together with freeze=1, then enb toggling -> state=1, acc=GAIN_INIT, no stale gain_valid; outputs hold while enb=0.
